// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: holding register, LSB-first framing, bit_tick paced
// Frame is start(0), FRAME_BITS data bits, STOP_BITS stop bits(1); no idle gap when a word is held.
module uart_tx #(
  parameter int FRAME_BITS = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  bit_tick,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_n;
  logic [FRAME_BITS-1:0] hold, hold_n;
  logic                  hold_full, hold_full_n;
  logic [FRAME_BITS-1:0] shifter, shifter_n;
  logic [CW-1:0]         bit_cnt, bit_cnt_n;
  logic                  stop_cnt, stop_cnt_n;
  logic                  tx_out_n, busy_n, tx_done_n;

  assign tx_ready = !hold_full;

  always_comb begin
    state_n     = state;
    hold_n      = hold;
    hold_full_n = hold_full;
    shifter_n   = shifter;
    bit_cnt_n   = bit_cnt;
    stop_cnt_n  = stop_cnt;
    tx_out_n    = tx_out;
    tx_done_n   = 1'b0;

    // Handshake needs an empty hold, a load needs a full one, so they never collide.
    if (tx_valid && !hold_full) begin
      hold_n      = tx_data;
      hold_full_n = 1'b1;
    end

    if (bit_tick) begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            shifter_n   = hold;
            hold_full_n = 1'b0;
            state_n     = START;
            tx_out_n    = 1'b0;
          end
        end
        START: begin
          state_n   = DATA;
          bit_cnt_n = '0;
          tx_out_n  = shifter[0];
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            state_n    = STOP;
            stop_cnt_n = 1'b0;
            tx_out_n   = 1'b1;
          end else begin
            shifter_n = shifter >> 1;
            bit_cnt_n = bit_cnt + 1'b1;
            tx_out_n  = shifter_n[0];
          end
        end
        STOP: begin
          if (stop_cnt == LAST_STOP) begin
            tx_done_n = 1'b1;
            if (hold_full) begin
              shifter_n   = hold;
              hold_full_n = 1'b0;
              state_n     = START;
              tx_out_n    = 1'b0;
            end else begin
              state_n  = IDLE;
              tx_out_n = 1'b1;
            end
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
            tx_out_n   = 1'b1;
          end
        end
        default: begin
          state_n  = IDLE;
          tx_out_n = 1'b1;
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
      shifter   <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      shifter   <= shifter_n;
      bit_cnt   <= bit_cnt_n;
      stop_cnt  <= stop_cnt_n;
      tx_out    <= tx_out_n;
      busy      <= busy_n;
      tx_done   <= tx_done_n;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx (one and two stop bit instances)
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       bit_tick = 1'b0;
  logic       tick_cont = 1'b0;
  logic [3:0] tick_cnt = 4'd0;
  logic [7:0] tx_data = 8'h00, tx_data2 = 8'h00;
  logic       tx_valid = 1'b0, tx_valid2 = 1'b0;
  logic       tx_ready, tx_out, busy, tx_done;
  logic       tx_ready2, tx_out2, busy2, tx_done2;
  logic       sel = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0, done_cnt = 0, done_cnt2 = 0, busy_cnt = 0, low_cnt = 0;
  int last_done = 0, prev_done = 0;

  uart_tx #(.FRAME_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .bit_tick(bit_tick), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .tx_done(tx_done));

  uart_tx #(.FRAME_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bit_tick(bit_tick), .tx_data(tx_data2),
    .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_out(tx_out2), .busy(busy2), .tx_done(tx_done2));

  wire cur_ready = sel ? tx_ready2 : tx_ready;
  wire cur_out   = sel ? tx_out2 : tx_out;
  wire cur_busy  = sel ? busy2 : busy;

  always #5 clk = ~clk;

  // One tick every 16 clk, or every clk when tick_cont is set.
  always @(negedge clk) begin
    tick_cnt <= tick_cnt + 4'd1;
    bit_tick <= tick_cont || (tick_cnt == 4'd15);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_done) begin
      done_cnt  <= done_cnt + 1;
      prev_done <= last_done;
      last_done <= cyc;
    end
    if (tx_done2) done_cnt2 <= done_cnt2 + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (!tx_out) low_cnt <= low_cnt + 1;
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] bp[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int t;
    t = 0;
    while (!cur_ready && t < 600) begin step(); t++; end
    if (t >= 600) begin
      checks++; errors++;
      $display("FAIL send_timeout: actual=tx_ready low required=high");
    end
    if (sel) begin tx_valid2 = 1'b1; tx_data2 = d; end
    else begin tx_valid = 1'b1; tx_data = d; end
    step();
    if (sel) begin tx_valid2 = 1'b0; tx_data2 = ~d; end
    else begin tx_valid = 1'b0; tx_data = ~d; end
  endtask

  task automatic get_frame(input int nbits, input int per, output logic [31:0] bits);
    int t;
    bits = '0;
    t = 0;
    while (cur_out !== 1'b0 && t < 600) begin step(); t++; end
    if (t >= 600) begin
      checks++; errors++;
      $display("FAIL start_timeout: actual=line high required=start bit");
      return;
    end
    repeat (per / 2) step();
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (per) step();
      bits[i] = cur_out;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((cur_busy || !cur_ready) && t < 600) begin step(); t++; end
    if (t >= 600) begin
      checks++; errors++;
      $display("FAIL idle_timeout: actual=busy required=idle");
    end
    repeat (2) step();
  endtask

  initial begin
    logic [31:0] bits;
    int d0, b0, l0;

    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h55, 10'b1010101010};
    vecs[5] = '{8'hAA, 10'b1101010100};
    bp[0] = 8'h11; bp[1] = 8'h22; bp[2] = 8'h33;

    #2 reset_n = 1'b0;
    repeat (3) step();
    check("reset_tx_out", tx_out, 1);
    check("reset_busy", busy, 0);
    check("reset_tx_done", tx_done, 0);
    check("reset_tx_ready", tx_ready, 1);
    reset_n = 1'b1;
    repeat (3) step();

    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      b0 = busy_cnt;
      send(vecs[v].data);
      get_frame(10, 16, bits);
      wait_idle();
      check($sformatf("frame_%0h", vecs[v].data), bits, {22'd0, vecs[v].frame});
      check($sformatf("done_%0h", vecs[v].data), done_cnt - d0, 1);
      check($sformatf("busy_len_%0h", vecs[v].data), busy_cnt - b0, 160);
    end

    d0 = done_cnt;
    fork
      begin send(8'h00); send(8'hFF); end
      get_frame(20, 16, bits);
    join
    wait_idle();
    check("b2b_frames", bits, {12'd0, 20'b1111111110_1000000000});
    check("b2b_done_cnt", done_cnt - d0, 2);
    check("b2b_done_gap", last_done - prev_done, 160);

    fork
      begin
        int t;
        logic r;
        tx_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tx_data = bp[k];
          t = 0;
          do begin r = tx_ready; step(); t++; end while (!r && t < 600);
          if (t >= 600) begin
            checks++; errors++;
            $display("FAIL bp_timeout: actual=no handshake required=handshake");
          end
          if (k == 0) check("bp_ready_low", tx_ready, 0);
        end
        tx_valid = 1'b0;
      end
      get_frame(30, 16, bits);
    join
    wait_idle();
    check("bp_order", bits, {2'd0, 30'b1001100110_1001000100_1000100010});

    sel = 1'b1;
    d0 = done_cnt2;
    send(8'h80);
    get_frame(11, 16, bits);
    check("stop2_frame", bits, {21'd0, 11'b11100000000});
    check("stop2_no_early_done", done_cnt2 - d0, 0);
    wait_idle();
    check("stop2_done", done_cnt2 - d0, 1);
    sel = 1'b0;

    send(8'h5A);
    send(8'hC3);
    get_frame(5, 16, bits);
    check("rst_partial", bits, {27'd0, 5'b10100});
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx_out", tx_out, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 1);
    step();
    reset_n = 1'b1;
    l0 = low_cnt;
    b0 = busy_cnt;
    repeat (400) step();
    check("rst_no_low", low_cnt - l0, 0);
    check("rst_no_busy", busy_cnt - b0, 0);

    tick_cont = 1'b1;
    step();
    d0 = done_cnt;
    b0 = busy_cnt;
    send(8'hA5);
    get_frame(10, 1, bits);
    wait_idle();
    check("cont_frame", bits, {22'd0, 10'b1101001010});
    check("cont_busy_len", busy_cnt - b0, 10);
    check("cont_done", done_cnt - d0, 1);
    tick_cont = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: it accepts parallel words over a valid/ready handshake and shifts them out LSB-first as 8N1-style frames (start bit 0, FRAME_BITS data bits, STOP_BITS stop bits at 1). Bit timing comes from an external one-cycle `bit_tick` pulse, one per bit period, produced by the shared baud generator. The block pairs with the design's UART receiver. A one-word holding register allows the next word to be loaded while the current frame is still on the line, so consecutive frames have no idle gap.

## Interface
- `FRAME_BITS`, default 8: data bits per frame; must be ≥ 1.
- `STOP_BITS`, default 1: stop bits per frame; legal values are 1 and 2.

- `clk`  input  1: single clock; all logic is on the rising edge.
- `reset_n`  input  1: reset, asynchronous and active-low.
- `bit_tick`  input  1: one-`clk` pulse marking each bit-period boundary.
- `tx_data`  input  FRAME_BITS: word to send; sampled on handshake.
- `tx_valid`  input  1: `tx_data` is valid.
- `tx_ready`  output  1: holding register is empty and can accept a word.
- `tx_out`  output  1: serial line; registered; idles high.
- `busy`  output  1: a frame is on the line (state ≠ IDLE); registered.
- `tx_done`  output  1: one-cycle pulse when a frame's last stop bit ends.

## Operation
- **Holding register** `hold`/`hold_full`
  - Handshake: `tx_valid && tx_ready` latches `tx_data` and sets `hold_full`.
  - `tx_ready = !hold_full`, combinational from the flop.
  - While `tx_ready=0`, `tx_valid` and `tx_data` are ignored.
- **Shift register** `shifter` (FRAME_BITS wide), **bit counter** (⌈log2 FRAME_BITS⌉ bits, minimum 1), **stop counter** (1 bit).
- **FSM**. Every transition occurs only on a cycle with `bit_tick=1`.
  - IDLE:
    - If `hold_full`: load `shifter`←`hold`, clear `hold_full`, go to START.
    - Otherwise stay in IDLE.
  - START: go to DATA with bit counter = 0.
  - DATA:
    - If counter = FRAME_BITS−1: go to STOP with stop counter = 0.
    - Otherwise: shift `shifter` right by 1 and increment the counter.
  - STOP:
    - If stop counter = STOP_BITS−1: pulse `tx_done`. Then, if `hold_full`, load `shifter`, clear `hold_full` and go to START (back-to-back); otherwise go to IDLE.
    - Otherwise: increment the stop counter.
- **`tx_out`** (registered, reflects the state entered):
  - IDLE: 1.
  - START: 0.
  - DATA: `shifter[0]`, LSB first.
  - STOP: 1.
- **Boundary conditions**
  - A handshake and a load can never occur in the same cycle, because a handshake needs `hold_full=0` and a load needs `hold_full=1`.
  - A handshake on the same cycle as a STOP→IDLE transition is captured. That word starts on the next `bit_tick`.
  - `bit_tick` held continuously high is legal: each bit lasts 1 `clk`.
  - `tx_data` changing after the handshake has no effect on the frame.
  - `reset_n` asserted mid-frame: the frame is aborted, the held word is discarded, and the line returns high immediately.

## Timing
- Reset values:
  - `tx_out`=1, `busy`=0, `tx_done`=0, `tx_ready`=1.
  - FSM=IDLE; `hold_full`, `shifter` and all counters = 0.
- Start-bit alignment: the start bit begins 1 `clk` after the first `bit_tick` that follows the handshake, in IDLE. Latency from handshake to the falling edge of `tx_out` is therefore 1 tick period + 1 `clk` at most.
- Each bit on `tx_out` lasts exactly one `bit_tick` period. Frame length is (1 + FRAME_BITS + STOP_BITS) tick periods.
- `tx_ready` falls 1 `clk` after the handshake. It rises 1 `clk` after the word moves into `shifter`, i.e. at the start of the start bit, so the next word can be queued for a full frame time.
- `tx_done` is high for the single `clk` following the final STOP tick. `busy` falls on that same edge, unless a back-to-back frame starts.
- Back-to-back frames: the STOP→START transition gives no idle bit; the stop bit is followed directly by the next start bit.

## Test plan
- **Single word:** FRAME_BITS=8, `bit_tick` every 16 `clk`, send 0xA5.
  - `tx_out` per period: 0,1,0,1,0,0,1,0,1,1.
  - One `tx_done` pulse; `busy` high for 160 `clk`.
- **Back-to-back:** send 0x00, then 0xFF as soon as `tx_ready` reasserts.
  - 20 contiguous bit periods with no high gap between frame 1's stop bit and frame 2's start bit.
  - Two `tx_done` pulses, 10 periods apart.
- **Backpressure:** hold `tx_valid`=1 with three words queued by the source.
  - `tx_ready`=0 while `hold` is full.
  - Words appear on the line in order 0x11, 0x22, 0x33; none is duplicated or dropped.
- **Two stop bits:** STOP_BITS=2, send 0x80.
  - `tx_out` = 0,0,0,0,0,0,0,0,1,1,1 (11 periods).
  - `tx_done` only after the second stop bit.
- **Reset mid-frame:** assert `reset_n`=0 during data bit 3 of 0x5A with a second word held.
  - `tx_out`=1, `busy`=0, `tx_ready`=1 within the same cycle.
  - After release, no output until a new handshake.
- **Loopback:** connect `tx_out` to the UART receiver through the 2-flop synchronizer, then send 0x00, 0x55, 0xAA, 0xFF.
  - Four receiver `valid` pulses carrying matching data.
  - `frame_error` stays 0.
